muldiv_unit: RTL and testbench

- Execute-stage HI/LO producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- The stall controller reads busy to hold MFHI/MFLO and new mul/div instructions in D until the result is committed.
- Multi-cycle operation: the result is computed from operands captured at start and committed to HI/LO after a fixed latency per op class.
- It writes the HI/LO values that MFHI/MFLO later read; those results flow through the pipeline like any cal_r result.

---
 rtl/ctldefine_pkg.sv | 18 +
 rtl/muldiv_calc.sv | 68 ++++++
 rtl/muldiv_unit.sv | 119 +++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctldefine_pkg.sv
// Shared control encodings for the execute-stage HI/LO unit.
// Op codes and default latencies used by muldiv_unit and its datapath.
package ctldefine;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/muldiv_calc.sv
// Combinational HI/LO result datapath for MULT/MULTU/DIV/DIVU.
// Signed division works on magnitudes; the result signs are fixed up afterwards.
module muldiv_calc
    import ctldefine::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign signed_div = (op == MD_DIV);
    assign neg_a      = signed_div & a[31];
    assign neg_b      = signed_div & b[31];
    assign mag_a      = neg_a ? (~a + 32'd1) : a;
    assign mag_b      = neg_b ? (~b + 32'd1) : b;

    // Keep the divider away from a zero divisor; that case is overridden below.
    assign div_b = (b == 32'd0) ? 32'd1 : mag_b;
    assign quo   = mag_a / div_b;
    assign rem   = mag_a % div_b;

    // 0x8000_0000 / -1 falls out naturally: |q| = 0x8000_0000 negates to itself.
    assign quo_s = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
    assign rem_s = neg_a ? (~rem + 32'd1) : rem;

    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        unique case (op)
            MD_MULT: begin
                hi_n = prod_s[63:32];
                lo_n = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_n = prod_u[63:32];
                lo_n = prod_u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi_n = a;
                    lo_n = 32'hFFFF_FFFF;
                end else begin
                    hi_n = rem_s;
                    lo_n = quo_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO producer: fixed-latency mul/div plus MTHI/MTLO.
// Result is computed at start and held until the commit edge.
module muldiv_unit
    import ctldefine::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    md_state_t     state;
    md_state_t     state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [31:0]   hi_n;
    logic [31:0]   lo_n;
    logic [31:0]   hi_p;
    logic [31:0]   lo_p;
    logic          launch;
    logic          commit;
    logic          wr_hi;
    logic          wr_lo;

    muldiv_calc u_calc (
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        launch  = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (start && !flush) begin
                    launch  = 1'b1;
                    state_d = MD_RUN;
                    cnt_d   = op[1] ? DIV_CNT : MUL_CNT;
                end else if (!start) begin
                    wr_hi = mthi;
                    wr_lo = mtlo;
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else if (cnt == '0) begin
                    commit  = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            hi_p  <= 32'd0;
            lo_p  <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (launch) begin
                hi_p <= hi_n;
                lo_p <= lo_n;
            end else if (state_d == MD_IDLE) begin
                hi_p <= 32'd0;
                lo_p <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            if (commit) begin
                hi <= hi_p;
                lo <= lo_p;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

    assign busy = (state == MD_RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && busy && start)
            $error("start asserted while busy");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (busy && cyc < 50) begin
            tick(1);
            if (busy) cyc++;
        end
        tick(1);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b hi=%h lo=%h expected 0/0/0",
                     busy, hi, lo);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid_run;
        a    = 32'h55;
        mthi = 1'b1;
        tick(1);
        mthi = 1'b0;
        chk("mthi_pre", hi, 32'h55);
        launch(2'd0, 32'hFFFF_FFFE, 32'd3);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid: busy=%b hi=%h lo=%h expected 0/0/0",
                     busy, hi, lo);
        end
        tick(1);
        rst_n = 1'b1;
        tick(10);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL rst_nocommit: busy=%b hi=%h lo=%h expected 0/0/0",
                     busy, hi, lo);
        end
    endtask

    task automatic test_op(input string nm, input logic [1:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input int lat, input logic [31:0] ehi,
                           input logic [31:0] elo);
        int cyc;
        logic [31:0] ohi;
        logic [31:0] olo;
        ohi = hi;
        olo = lo;
        launch(o, x, y);
        chk({nm, "_hold_hi"}, hi, ohi);
        chk({nm, "_hold_lo"}, lo, olo);
        wait_done(cyc);
        chk({nm, "_lat"}, cyc, lat);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
    endtask

    task automatic test_arith;
        test_op("mult", 2'd0, 32'hFFFF_FFFE, 32'd3, 5,
                32'hFFFF_FFFF, 32'hFFFF_FFFA);
        test_op("multu", 2'd1, 32'hFFFF_FFFE, 32'd3, 5,
                32'h0000_0002, 32'hFFFF_FFFA);
        test_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 10,
                32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_op("divu", 2'd3, 32'd100, 32'd7, 10,
                32'd2, 32'd14);
        test_op("div_mix", 2'd2, 32'd7, 32'hFFFF_FFFE, 10,
                32'd1, 32'hFFFF_FFFD);
    endtask

    task automatic test_edges;
        test_op("divu_z", 2'd3, 32'd123, 32'd0, 10,
                32'd123, 32'hFFFF_FFFF);
        test_op("div_z", 2'd2, 32'hFFFF_FFF0, 32'd0, 10,
                32'hFFFF_FFF0, 32'hFFFF_FFFF);
        test_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
                32'd0, 32'h8000_0000);
    endtask

    task automatic test_flush;
        logic [31:0] ohi;
        logic [31:0] olo;
        ohi = hi;
        olo = lo;
        launch(2'd2, 32'd100, 32'd7);
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        tick(12);
        chk("flush_hi", hi, ohi);
        chk("flush_lo", lo, olo);

        op    = 2'd1;
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        tick(1);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        tick(6);
        chk("flush_start_lo", lo, olo);

        launch(2'd1, 32'd9, 32'd9);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_commit_busy", {31'd0, busy}, 32'd0);
        chk("flush_commit_lo", lo, olo);
        chk("flush_commit_hi", hi, ohi);
    endtask

    task automatic test_mtlo;
        logic [31:0] ohi;
        ohi  = hi;
        a    = 32'd5;
        mtlo = 1'b1;
        tick(1);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'd5);
        chk("mtlo_hi", hi, ohi);
        a    = 32'hCAFE_0001;
        mthi = 1'b1;
        mtlo = 1'b1;
        tick(1);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mtboth_hi", hi, 32'hCAFE_0001);
        chk("mtboth_lo", lo, 32'hCAFE_0001);
    endtask

    task automatic test_mthi_busy;
        int cyc;
        launch(2'd1, 32'd2, 32'd3);
        tick(1);
        a    = 32'hDEAD_BEEF;
        mthi = 1'b1;
        tick(1);
        mthi = 1'b0;
        chk("mthi_busy_hold", hi, 32'hCAFE_0001);
        wait_done(cyc);
        chk("mthi_busy_hi", hi, 32'd0);
        chk("mthi_busy_lo", lo, 32'd6);

        op    = 2'd0;
        a     = 32'd4;
        b     = 32'd4;
        start = 1'b1;
        mtlo  = 1'b1;
        tick(1);
        start = 1'b0;
        mtlo  = 1'b0;
        chk("mtlo_start_lo", lo, 32'd6);
        wait_done(cyc);
        chk("mtlo_start_res", lo, 32'd16);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        flush = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_arith();
        test_edges();
        test_flush();
        test_mtlo();
        test_mthi_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
